// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch unit. It holds the program counter and issues
//   single-word reads to instruction memory on request. The returned word is
//   captured into an instruction register, which also drives the decoded
//   field outputs.
//
//   Parameters
//     RESET_PC  PC value loaded on reset
//     PC_STEP   word-address increment for the sequential PC
//     TIMEOUT   maximum REQ cycles without imemAck (timeout build only)
//
//   Ports
//     clk, rst            clock; synchronous active-high reset
//     fetchStart          one-cycle pulse: fetch the word at the current pc
//     incPC, brTaken      PC update strobe; brTaken selects brTarget
//     brTarget            branch target address
//     halt                blocks new fetches while high
//     imemReq, imemAddr   instruction-memory read request and address
//     imemAck, imemData   memory response strobe and returned word
//     pc, instr           PC register and instruction register
//     opcode..func        fields decoded from instr
//     instrValid          instr holds a fetched word not yet superseded
//     busy                a memory request is outstanding
//     fetchErr            sticky fetch-timeout flag
//
//   Build option
//     IFETCH_TIMEOUT_EN   when defined, a request that gets no imemAck within
//                         TIMEOUT cycles moves the unit to an error state that
//                         only rst can leave. When undefined, a request waits
//                         indefinitely and fetchErr is tied low.
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetchStart,
    input  logic        incPC,
    input  logic        brTaken,
    input  logic [31:0] brTarget,
    input  logic        halt,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic [3:0]  func,
    output logic        instrValid,
    output logic        busy,
    output logic        fetchErr
);

`ifdef IFETCH_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Last count value before the error transition; an ack in that same
    // cycle still takes priority.
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] tCount;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1
    } state_t;
`endif

    state_t      state;
    logic        pending;
    logic [31:0] pendPC;
    logic [31:0] nextPC;

    // Candidate PC for an incPC strobe in the current cycle. pc is frozen
    // while a request is outstanding, so this is also the value stored for
    // a deferred update.
    always_comb begin
        nextPC = brTaken ? brTarget : (pc + PC_STEP);
    end

    // imemAddr always reflects pc. Updates requested during REQ are parked
    // in pendPC until the ack edge, which keeps the address stable for the
    // whole request.
    assign imemAddr = pc;
    assign busy     = (state == REQ);

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign imm    = instr[15:0];
    assign func   = instr[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instr      <= '0;
            instrValid <= 1'b0;
            imemReq    <= 1'b0;
            pending    <= 1'b0;
            pendPC     <= '0;
`ifdef IFETCH_TIMEOUT_EN
            tCount     <= '0;
            fetchErr   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (incPC) begin
                        pc <= nextPC;
                    end
                    if (fetchStart && !halt) begin
                        state      <= REQ;
                        imemReq    <= 1'b1;
                        instrValid <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
                        tCount     <= '0;
`endif
                    end
                end

                REQ: begin
                    // fetchStart and halt have no effect once a request is out.
                    if (imemAck) begin
                        instr      <= imemData;
                        instrValid <= 1'b1;
                        imemReq    <= 1'b0;
                        state      <= IDLE;
                        pending    <= 1'b0;
                        // A strobe in the ack cycle is the newest update and
                        // supersedes any parked one.
                        if (incPC) begin
                            pc <= nextPC;
                        end else if (pending) begin
                            pc <= pendPC;
                        end
                    end else begin
                        if (incPC) begin
                            pending <= 1'b1;
                            pendPC  <= nextPC;
                        end
`ifdef IFETCH_TIMEOUT_EN
                        if (tCount == T_LAST) begin
                            state    <= ERR;
                            imemReq  <= 1'b0;
                            fetchErr <= 1'b1;
                        end else begin
                            tCount <= tCount + 1'b1;
                        end
`endif
                    end
                end

`ifdef IFETCH_TIMEOUT_EN
                ERR: begin
                    // Terminal until rst; fetchStart and incPC are ignored.
                    imemReq <= 1'b0;
                end
`endif

                default: begin
                    state   <= IDLE;
                    imemReq <= 1'b0;
                end
            endcase
        end
    end

`ifndef IFETCH_TIMEOUT_EN
    assign fetchErr = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed self-checking bench for instr_fetch. Inputs change 1 ns after a
//   rising edge and outputs are examined at the same point, so each check sees
//   the state left by the preceding edge. The timeout scenario follows the
//   IFETCH_TIMEOUT_EN build option.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetchStart;
    logic        incPC;
    logic        brTaken;
    logic [31:0] brTarget;
    logic        halt;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [3:0]  func;
    logic        instrValid;
    logic        busy;
    logic        fetchErr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd1),
        .TIMEOUT  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetchStart (fetchStart),
        .incPC      (incPC),
        .brTaken    (brTaken),
        .brTarget   (brTarget),
        .halt       (halt),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemAck    (imemAck),
        .imemData   (imemData),
        .pc         (pc),
        .instr      (instr),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm        (imm),
        .func       (func),
        .instrValid (instrValid),
        .busy       (busy),
        .fetchErr   (fetchErr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetchStart = 1'b0; incPC = 1'b0; brTaken = 1'b0;
        brTarget = '0; halt = 1'b0; imemAck = 1'b0; imemData = '0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected %h", instr, 32'h0); end
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instrValid); end
        checks++; if (imemReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imemReq); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (fetchErr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", fetchErr); end
    endtask

    task automatic test_fetch_decode();
        fetchStart = 1'b1;
        tick();
        fetchStart = 1'b0;
        checks++; if (imemReq !== 1'b1) begin errors++; $display("FAIL fd_req: got %b expected 1", imemReq); end
        checks++; if (imemAddr !== 32'h0) begin errors++; $display("FAIL fd_addr: got %h expected %h", imemAddr, 32'h0); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fd_busy: got %b expected 1", busy); end
        imemAck = 1'b1; imemData = 32'h0443_2805;
        tick();
        imemAck = 1'b0; imemData = '0;
        checks++; if (instrValid !== 1'b1) begin errors++; $display("FAIL fd_valid: got %b expected 1", instrValid); end
        checks++; if (instr !== 32'h0443_2805) begin errors++; $display("FAIL fd_instr: got %h expected %h", instr, 32'h0443_2805); end
        checks++; if (opcode !== 6'h01) begin errors++; $display("FAIL fd_opcode: got %h expected %h", opcode, 6'h01); end
        checks++; if (rs !== 5'd2) begin errors++; $display("FAIL fd_rs: got %0d expected 2", rs); end
        checks++; if (rt !== 5'd3) begin errors++; $display("FAIL fd_rt: got %0d expected 3", rt); end
        checks++; if (rd !== 5'd5) begin errors++; $display("FAIL fd_rd: got %0d expected 5", rd); end
        checks++; if (imm !== 16'h2805) begin errors++; $display("FAIL fd_imm: got %h expected %h", imm, 16'h2805); end
        checks++; if (func !== 4'h5) begin errors++; $display("FAIL fd_func: got %h expected 5", func); end
        checks++; if (imemReq !== 1'b0) begin errors++; $display("FAIL fd_req_done: got %b expected 0", imemReq); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL fd_pc: got %h expected %h", pc, 32'h0); end
    endtask

    task automatic test_pc_wrap();
        incPC = 1'b1; brTaken = 1'b1; brTarget = 32'hFFFF_FFFF;
        tick();
        checks++; if (pc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_load: got %h expected %h", pc, 32'hFFFF_FFFF); end
        brTaken = 1'b0;
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_seq: got %h expected %h", pc, 32'h0); end
        brTaken = 1'b1; brTarget = 32'h40;
        tick();
        incPC = 1'b0; brTaken = 1'b0;
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL wrap_branch: got %h expected %h", pc, 32'h40); end
    endtask

    task automatic test_deferred_inc();
        incPC = 1'b1; brTaken = 1'b1; brTarget = 32'h8;
        tick();
        incPC = 1'b0; brTaken = 1'b0;
        fetchStart = 1'b1;
        tick();
        fetchStart = 1'b0;
        checks++; if (imemAddr !== 32'h8) begin errors++; $display("FAIL def_addr1: got %h expected %h", imemAddr, 32'h8); end
        tick();
        incPC = 1'b1;
        tick();
        incPC = 1'b0;
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL def_pc_held: got %h expected %h", pc, 32'h8); end
        checks++; if (imemAddr !== 32'h8) begin errors++; $display("FAIL def_addr2: got %h expected %h", imemAddr, 32'h8); end
        checks++; if (imemReq !== 1'b1) begin errors++; $display("FAIL def_req: got %b expected 1", imemReq); end
        tick();
        checks++; if (imemAddr !== 32'h8) begin errors++; $display("FAIL def_addr3: got %h expected %h", imemAddr, 32'h8); end
        imemAck = 1'b1; imemData = 32'h1234_5678;
        tick();
        imemAck = 1'b0;
        checks++; if (instr !== 32'h1234_5678) begin errors++; $display("FAIL def_instr: got %h expected %h", instr, 32'h1234_5678); end
        checks++; if (pc !== 32'h9) begin errors++; $display("FAIL def_pc_after: got %h expected %h", pc, 32'h9); end
        checks++; if (instrValid !== 1'b1) begin errors++; $display("FAIL def_valid: got %b expected 1", instrValid); end
    endtask

    task automatic test_overwrite_and_same_cycle();
        fetchStart = 1'b1;
        tick();
        fetchStart = 1'b0;
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL ow_valid_clear: got %b expected 0", instrValid); end
        checks++; if (imemAddr !== 32'h9) begin errors++; $display("FAIL ow_addr: got %h expected %h", imemAddr, 32'h9); end
        incPC = 1'b1; brTaken = 1'b1; brTarget = 32'h100; fetchStart = 1'b1;
        tick();
        brTaken = 1'b0; fetchStart = 1'b0;
        tick();
        incPC = 1'b0;
        checks++; if (pc !== 32'h9) begin errors++; $display("FAIL ow_pc_held: got %h expected %h", pc, 32'h9); end
        imemAck = 1'b1; imemData = 32'hDEAD_BEEF;
        tick();
        imemAck = 1'b0;
        checks++; if (pc !== 32'hA) begin errors++; $display("FAIL ow_pc: got %h expected %h", pc, 32'hA); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ow_busy: got %b expected 0", busy); end
        fetchStart = 1'b1;
        tick();
        fetchStart = 1'b0;
        checks++; if (imemAddr !== 32'hA) begin errors++; $display("FAIL sc_addr: got %h expected %h", imemAddr, 32'hA); end
        incPC = 1'b1; brTaken = 1'b1; brTarget = 32'h200;
        imemAck = 1'b1; imemData = 32'hCAFE_F00D;
        tick();
        incPC = 1'b0; brTaken = 1'b0; imemAck = 1'b0;
        checks++; if (instr !== 32'hCAFE_F00D) begin errors++; $display("FAIL sc_instr: got %h expected %h", instr, 32'hCAFE_F00D); end
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL sc_pc: got %h expected %h", pc, 32'h200); end
    endtask

    task automatic test_halt();
        halt = 1'b1; fetchStart = 1'b1;
        tick();
        fetchStart = 1'b0;
        checks++; if (imemReq !== 1'b0) begin errors++; $display("FAIL halt_req: got %b expected 0", imemReq); end
        checks++; if (instrValid !== 1'b1) begin errors++; $display("FAIL halt_valid: got %b expected 1", instrValid); end
        halt = 1'b0; fetchStart = 1'b1;
        tick();
        fetchStart = 1'b0; halt = 1'b1;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL halt_busy: got %b expected 1", busy); end
        imemAck = 1'b1; imemData = 32'h1111_2222;
        tick();
        imemAck = 1'b0; halt = 1'b0;
        checks++; if (instr !== 32'h1111_2222) begin errors++; $display("FAIL halt_instr: got %h expected %h", instr, 32'h1111_2222); end
        checks++; if (instrValid !== 1'b1) begin errors++; $display("FAIL halt_valid2: got %b expected 1", instrValid); end
    endtask

    task automatic test_reset_mid();
        fetchStart = 1'b1;
        tick();
        fetchStart = 1'b0;
        // Reset together with competing inputs; reset must win.
        rst = 1'b1; incPC = 1'b1; fetchStart = 1'b1;
        imemAck = 1'b1; imemData = 32'h5555_5555;
        tick();
        rst = 1'b0; incPC = 1'b0; fetchStart = 1'b0;
        checks++; if (imemReq !== 1'b0) begin errors++; $display("FAIL rm_req: got %b expected 0", imemReq); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rm_pc: got %h expected %h", pc, 32'h0); end
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", instrValid); end
        tick();
        imemAck = 1'b0;
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rm_instr: got %h expected %h", instr, 32'h0); end
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL rm_late_ack: got %b expected 0", instrValid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", busy); end
    endtask

`ifdef IFETCH_TIMEOUT_EN
    task automatic test_timeout();
        fetchStart = 1'b1;
        tick();
        fetchStart = 1'b0;
        repeat (3) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy: got %b expected 1", busy); end
        checks++; if (fetchErr !== 1'b0) begin errors++; $display("FAIL to_early: got %b expected 0", fetchErr); end
        tick();
        checks++; if (fetchErr !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", fetchErr); end
        checks++; if (imemReq !== 1'b0) begin errors++; $display("FAIL to_req: got %b expected 0", imemReq); end
        fetchStart = 1'b1; incPC = 1'b1;
        tick();
        fetchStart = 1'b0; incPC = 1'b0;
        checks++; if (imemReq !== 1'b0) begin errors++; $display("FAIL to_ignore_req: got %b expected 0", imemReq); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL to_ignore_pc: got %h expected %h", pc, 32'h0); end
        checks++; if (fetchErr !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", fetchErr); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (fetchErr !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", fetchErr); end
        fetchStart = 1'b1;
        tick();
        fetchStart = 1'b0;
        repeat (3) tick();
        imemAck = 1'b1; imemData = 32'h0BAD_F00D;
        tick();
        imemAck = 1'b0;
        checks++; if (fetchErr !== 1'b0) begin errors++; $display("FAIL to_ack_wins: got %b expected 0", fetchErr); end
        checks++; if (instr !== 32'h0BAD_F00D) begin errors++; $display("FAIL to_ack_instr: got %h expected %h", instr, 32'h0BAD_F00D); end
    endtask
`else
    task automatic test_timeout();
        fetchStart = 1'b1;
        tick();
        fetchStart = 1'b0;
        repeat (20) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nt_busy: got %b expected 1", busy); end
        checks++; if (imemReq !== 1'b1) begin errors++; $display("FAIL nt_req: got %b expected 1", imemReq); end
        checks++; if (fetchErr !== 1'b0) begin errors++; $display("FAIL nt_err: got %b expected 0", fetchErr); end
        imemAck = 1'b1; imemData = 32'h0BAD_F00D;
        tick();
        imemAck = 1'b0;
        checks++; if (instr !== 32'h0BAD_F00D) begin errors++; $display("FAIL nt_instr: got %h expected %h", instr, 32'h0BAD_F00D); end
        checks++; if (instrValid !== 1'b1) begin errors++; $display("FAIL nt_valid: got %b expected 1", instrValid); end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch_decode();
        test_pc_wrap();
        test_deferred_inc();
        test_overwrite_and_same_cycle();
        test_halt();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
